// File: rtl/mips_pkg.sv
// Shared encodings for the fetch/PC stage and control_unit.
package mips_pkg;

    localparam logic [2:0] PC_SEQ    = 3'b000;
    localparam logic [2:0] PC_JUMP   = 3'b001;
    localparam logic [2:0] PC_JR     = 3'b010;
    localparam logic [2:0] PC_BRANCH = 3'b011;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_RESET = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_ERROR = 2'b11
    } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential, jump, register jump and branch targets.
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  pc_control,
    input  logic [25:0] jump_addr,
    input  logic [15:0] branch_imm,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] pc_plus4;
    logic [31:0] br_off;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    // Reserved 1xx encodings fall through to sequential.
    always_comb begin
        next_pc  = pc_plus4;
        misalign = 1'b0;
        case (pc_control)
            PC_JUMP:   next_pc = {pc_plus4[31:28], jump_addr, 2'b00};
            PC_JR: begin
                next_pc  = jr_target;
                misalign = (jr_target[1:0] != 2'b00);
            end
            PC_BRANCH: next_pc = pc_plus4 + br_off;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Multi-cycle PC and instruction-fetch stage: fetch over req/ack,
// hold the instruction for one execute cycle, then advance the PC.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pc_control,
    input  logic [25:0] jump_addr,
    input  logic [15:0] branch_imm,
    input  logic [31:0] jr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_error
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] next_pc;
    logic        misalign;

    pc_next_calc u_next (
        .pc         (pc_q),
        .pc_control (pc_control),
        .jump_addr  (jump_addr),
        .branch_imm (branch_imm),
        .jr_target  (jr_target),
        .next_pc    (next_pc),
        .misalign   (misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            pc_q    <= RESET_PC;
            instr_q <= MIPS_NOP;
            cnt_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
                cnt_d   = 32'd0;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = 32'd0;
                    state_d = S_EXEC;
                end else if (TIMEOUT != 0 &&
                             cnt_q + 32'd1 == TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_EXEC: begin
                // pc_control only matters on the edge that leaves EXEC.
                if (!stall) begin
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        pc_d    = next_pc;
                        cnt_d   = 32'd0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_EXEC);
    assign instruction = instr_valid ? instr_q : MIPS_NOP;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_error = err_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter and instruction-fetch stage that sits directly upstream of control_unit. It holds the architectural PC and fetches one instruction from instruction memory over a req/ack handshake. It presents the instruction to control_unit for one execute cycle, then computes the next PC from control_unit's pc_control. Multi-cycle, non-pipelined: the cycle is fetch, then execute, then fetch again.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
TIMEOUT, 16, max consecutive unacked fetch cycles before fetch_error; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
pc_control  input  3  next-PC select from control_unit: 000 seq, 001 j/jal, 010 jr, 011 taken branch.
jump_addr  input  26  jump target field (instruction[25:0]).
branch_imm  input  16  branch offset field (instruction[15:0]).
jr_target  input  32  rs register value for jr.
stall  input  1  holds the execute cycle; no PC update while high.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; equals pc.
imem_ack  input  1  instruction memory has valid imem_rdata this cycle.
imem_rdata  input  32  fetched instruction word.
instruction  output  32  to control_unit; 32'h0 (NOP) whenever instr_valid=0.
instr_valid  output  1  instruction is in its execute cycle.
pc  output  32  current PC.
pc_plus4  output  32  pc+4; used as the jal link value.
fetch_error  output  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fetch or mid-execute): pc=RESET_PC, state=S_RESET, imem_req=0, instr_valid=0, instruction=0, fetch_error=0, timeout counter=0.
- S_RESET: next edge goes to S_FETCH with imem_req=1.
- S_FETCH:
  - imem_req is held at 1 and imem_addr=pc stays stable until imem_ack is sampled high.
  - On the edge with ack: latch instruction from imem_rdata, set instr_valid=1, set imem_req=0, go to S_EXEC.
  - If TIMEOUT>0 and TIMEOUT consecutive edges pass without ack: fetch_error=1, go to S_ERROR.
- S_EXEC:
  - instruction and instr_valid are held stable.
  - pc_control is sampled only on the edge that leaves S_EXEC. That is the first edge with stall=0, so a stall lasts exactly the number of cycles stall is high.
  - While stall=1: state, pc and instruction are held; pc_control is ignored.
  - On leaving: pc<=next_pc, instr_valid=0, imem_req=1, go to S_FETCH.
- next_pc, all arithmetic modulo 2^32:
  - 000: pc+4. 0xFFFFFFFC wraps to 0x00000000.
  - 001: {pc_plus4[31:28], jump_addr, 2'b00}.
  - 010: jr_target. If jr_target[1:0]!=0: fetch_error=1, go to S_ERROR, pc unchanged.
  - 011: pc_plus4 + ({{14{branch_imm[15]}}, branch_imm, 2'b00}).
  - 1xx: treated as 000 (no error).
- S_ERROR: terminal until rst. imem_req=0, instr_valid=0, instruction=0, pc frozen.
- imem_ack in any state other than S_FETCH is ignored. Unknown state encodings recover to S_ERROR.
- No branch delay slot. jal link value is pc_plus4 of the jal instruction.

Decomposition:
- Shared package mips_pkg holds:
  - pc_control encodings PC_SEQ=3'b000, PC_JUMP=3'b001, PC_JR=3'b010, PC_BRANCH=3'b011.
  - MIPS_NOP=32'h0.
  - FSM state encodings S_RESET, S_FETCH, S_EXEC, S_ERROR.
- One combinational sub-module, pc_next_calc, takes pc, pc_control, jump_addr, branch_imm and jr_target, and produces next_pc and a misalign flag.

Test Plan:
1. RESET_PC=0x00400000; release rst; ack 2 cycles after imem_req with rdata 0x20080005. Required: imem_addr=0x00400000; instruction=0x20080005 with instr_valid for exactly 1 cycle; next imem_addr=0x00400004.
2. pc=0x00400010, pc_control=011, branch_imm=16'hFFFC -> next pc=0x00400004. Repeat with pc_control=000 -> 0x00400014.
3. pc=0x00400020, pc_control=001, jump_addr=26'h0100040 -> next pc=0x00400100. pc_plus4=0x00400024 during S_EXEC.
4. pc_control=010, jr_target=0x00400002 -> fetch_error=1, pc stays put, imem_req stays 0 forever. Assert rst -> fetch_error=0, pc=RESET_PC.
5. stall=1 for 3 cycles in S_EXEC while pc_control toggles 011->001->000 -> instruction and pc held, no imem_req; only the value present on the stall=0 edge (000) is applied.
6. TIMEOUT=4, never ack -> fetch_error rises on the 4th edge in S_FETCH. Separately, pc=0xFFFFFFFC with pc_control=000 -> next pc=0x00000000. Separately, assert rst mid-S_FETCH -> imem_req drops with no clock edge.
